// File: rtl/astrio_branch_predictor_if.sv
// astrio_branch_predictor_if: lookup, update and statistics bundle between fetch/decode and the predictor.
interface astrio_branch_predictor_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_next_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic              flush_all;
  logic [31:0]       stat_lookups;
  logic [31:0]       stat_hits;
  logic [31:0]       stat_mispredicts;
  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
    input  pred_hit, pred_taken, pred_next_pc, stat_lookups, stat_hits, stat_mispredicts
  );
  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
    output pred_hit, pred_taken, pred_next_pc, stat_lookups, stat_hits, stat_mispredicts
  );
endinterface

// File: rtl/astrio_branch_predictor.sv
// astrio_branch_predictor: direct-mapped BTB with saturating direction counters and combinational lookup.
// Define ASTRIO_BP_STATS_EN to build the lookup/hit/mispredict statistics counters.
module astrio_branch_predictor #(
  parameter int ADDR_W   = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input logic clk,
  input logic rst_n,
  astrio_branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  logic [ENTRIES-1:0]  valid;
  logic [TAG_W-1:0]    tag    [ENTRIES];
  logic [ADDR_W-1:0]   target [ENTRIES];
  logic [CTR_BITS-1:0] ctr    [ENTRIES];

  logic [IDX_W-1:0]    l_idx, u_idx;
  logic [TAG_W-1:0]    l_tag, u_tag;
  logic                hit, taken, u_hit;
  logic [CTR_BITS-1:0] u_ctr, ctr_nxt;
  logic                unused;

  always_comb begin
    l_idx   = bp.lookup_pc[IDX_W+1:2];
    l_tag   = bp.lookup_pc[ADDR_W-1:IDX_W+2];
    u_idx   = bp.upd_pc[IDX_W+1:2];
    u_tag   = bp.upd_pc[ADDR_W-1:IDX_W+2];
    hit     = valid[l_idx] && tag[l_idx] == l_tag;
    taken   = hit && ctr[l_idx][CTR_BITS-1];
    u_hit   = valid[u_idx] && tag[u_idx] == u_tag;
    u_ctr   = ctr[u_idx];
    ctr_nxt = !u_hit ? CTR_WT :
              bp.upd_taken ? (u_ctr == CTR_MAX ? u_ctr : u_ctr + CTR_BITS'(1)) :
              (u_ctr == '0 ? u_ctr : u_ctr - CTR_BITS'(1));
  end

  assign bp.pred_hit     = hit;
  assign bp.pred_taken   = taken;
  assign bp.pred_next_pc = taken ? target[l_idx] : bp.lookup_pc + ADDR_W'(4);

  // Misses only allocate on taken outcomes, so not-taken aliases never evict a live entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_WNT;
      end
    end else if (bp.flush_all) begin
      valid <= '0;
    end else if (bp.upd_valid && (u_hit || bp.upd_taken)) begin
      valid[u_idx] <= 1'b1;
      tag[u_idx]   <= u_tag;
      ctr[u_idx]   <= ctr_nxt;
      if (bp.upd_taken) target[u_idx] <= bp.upd_target;
    end
  end

`ifdef ASTRIO_BP_STATS_EN
  logic [31:0] n_look, n_hit, n_mis;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_look <= '0;
      n_hit  <= '0;
      n_mis  <= '0;
    end else begin
      n_look <= n_look + 32'(n_look != '1);
      n_hit  <= n_hit + 32'(hit && n_hit != '1);
      n_mis  <= n_mis + 32'(bp.upd_valid && bp.upd_mispredict && n_mis != '1);
    end
  end
  assign bp.stat_lookups     = n_look;
  assign bp.stat_hits        = n_hit;
  assign bp.stat_mispredicts = n_mis;
`else
  assign bp.stat_lookups     = '0;
  assign bp.stat_hits        = '0;
  assign bp.stat_mispredicts = '0;
`endif

  assign unused = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0], bp.upd_mispredict};
endmodule

// File: tb/tb_astrio_branch_predictor.sv
// tb_astrio_branch_predictor: directed checks of lookup, counter training, aliasing, flush, reset and stats.
module tb_astrio_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0050;
  localparam logic [31:0] PC = 32'h0040_0090;
  localparam logic [31:0] PD = 32'h0040_0020;
  localparam logic [31:0] PE = 32'h0040_0030;

  astrio_branch_predictor_if #(.ADDR_W(32)) bp ();
  astrio_branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .bp(bp.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bp.upd_valid = 0; bp.upd_pc = '0; bp.upd_taken = 0; bp.upd_target = '0;
    bp.upd_mispredict = 0; bp.flush_all = 0;
  endtask

  task automatic do_reset;
    idle();
    bp.lookup_pc = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bp.upd_valid = 1; bp.upd_pc = pc; bp.upd_taken = tk; bp.upd_target = tgt;
    tick();
    idle();
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] en, input string nm);
    bp.lookup_pc = pc;
    #1;
    checks++;
    if ({bp.pred_hit, bp.pred_taken, bp.pred_next_pc} !== {eh, et, en}) begin
      errors++;
      $display("FAIL %s: hit/taken/next got %b/%b/%h expected %b/%b/%h", nm,
               bp.pred_hit, bp.pred_taken, bp.pred_next_pc, eh, et, en);
    end
  endtask

  task automatic test_reset;
    do_reset();
    look(PA, 0, 0, 32'h0040_0014, "reset_lookup");
    look(32'hFFFF_FFFC, 0, 0, 32'h0000_0000, "pc4_wrap");
  endtask

  task automatic test_alloc;
    look(PA, 0, 0, PA + 4, "pre_alloc");
    bp.upd_valid = 1; bp.upd_pc = PA; bp.upd_taken = 1; bp.upd_target = 32'h0040_0100;
    look(PA, 0, 0, PA + 4, "same_cycle_no_bypass");
    tick();
    idle();
    look(PA, 1, 1, 32'h0040_0100, "after_alloc");
  endtask

  task automatic test_counter;
    upd(PA, 0, '0);                 look(PA, 1, 0, PA + 4, "ctr_10_to_01");
    upd(PA, 0, '0);                 look(PA, 1, 0, PA + 4, "ctr_01_to_00");
    upd(PA, 0, '0);                 look(PA, 1, 0, PA + 4, "ctr_hold_00");
    upd(PA, 1, 32'h0040_0200);      look(PA, 1, 0, PA + 4, "ctr_00_to_01");
    upd(PA, 1, 32'h0040_0200);      look(PA, 1, 1, 32'h0040_0200, "ctr_01_to_10");
    upd(PA, 1, 32'h0040_0200);      look(PA, 1, 1, 32'h0040_0200, "ctr_10_to_11");
    upd(PA, 1, 32'h0040_0200);      look(PA, 1, 1, 32'h0040_0200, "ctr_hold_11");
    upd(PA, 0, 32'h0000_0ABC);      look(PA, 1, 1, 32'h0040_0200, "ctr_11_to_10_target_kept");
    upd(PA, 0, '0);                 look(PA, 1, 0, PA + 4, "ctr_10_to_01_again");
  endtask

  task automatic test_alias;
    upd(PB, 1, 32'h0000_0800);
    look(PA, 0, 0, PA + 4, "alias_evicted");
    look(PB, 1, 1, 32'h0000_0800, "alias_new_hit");
    upd(PC, 0, 32'h0000_0444);
    look(PB, 1, 1, 32'h0000_0800, "alias_nt_no_evict");
    look(PC, 0, 0, PC + 4, "alias_nt_miss");
  endtask

  task automatic test_flush;
    bp.flush_all = 1; bp.upd_valid = 1; bp.upd_pc = PD; bp.upd_taken = 1; bp.upd_target = 32'h0000_0300;
    tick();
    idle();
    look(PB, 0, 0, PB + 4, "flush_clears_b");
    look(PD, 0, 0, PD + 4, "flush_beats_update");
    upd(PD, 1, 32'h0000_0300);
    look(PD, 1, 1, 32'h0000_0300, "realloc_after_flush");
  endtask

  task automatic test_async_reset;
    bp.lookup_pc = PD;
    #2;
    rst_n = 0;
    look(PD, 0, 0, PD + 4, "async_reset_immediate");
    bp.upd_valid = 1; bp.upd_pc = PE; bp.upd_taken = 1; bp.upd_target = 32'h0000_0900;
    tick();
    idle();
    rst_n = 1;
    look(PE, 0, 0, PE + 4, "reset_discards_update");
  endtask

  task automatic test_stats;
    logic [31:0] el, eh, em;
    do_reset();
    bp.lookup_pc = PA;
    bp.upd_valid = 1; bp.upd_pc = PA; bp.upd_taken = 1; bp.upd_target = 32'h0040_0100; bp.upd_mispredict = 1;
    tick();
    bp.upd_taken = 0; bp.upd_mispredict = 1;
    tick();
    idle();
    repeat (3) @(posedge clk);
    #1;
    bp.lookup_pc = PB;
    repeat (5) @(posedge clk);
    #1;
`ifdef ASTRIO_BP_STATS_EN
    el = 10; eh = 4; em = 2;
`else
    el = 0; eh = 0; em = 0;
`endif
    checks++;
    if (bp.stat_lookups !== el) begin errors++; $display("FAIL stat_lookups: got %0d expected %0d", bp.stat_lookups, el); end
    checks++;
    if (bp.stat_hits !== eh) begin errors++; $display("FAIL stat_hits: got %0d expected %0d", bp.stat_hits, eh); end
    checks++;
    if (bp.stat_mispredicts !== em) begin errors++; $display("FAIL stat_mispredicts: got %0d expected %0d", bp.stat_mispredicts, em); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_flush();
    test_async_reset();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
